// File: rtl/iter_alu.sv
// Multi-cycle ALU: logic/arithmetic ops finish in one cycle; SLL/SRL shift one bit per cycle.
// Define ITER_ALU_BARREL_SHIFT_EN to replace the iterative shifter with a one-cycle barrel shifter.
module iter_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ALUcontrol,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SLL  = 4'd3;
    localparam logic [3:0] OP_SRL  = 4'd4;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd9;
    localparam logic [3:0] OP_NOR  = 4'd12;
    localparam logic [3:0] OP_SLTU = 4'd14;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q;
    logic             ready_q, done_q, zero_q, illegal_q, left_q;
    logic [WIDTH-1:0] result_q, work_q;
    logic [4:0]       cnt_q;

    logic [4:0]       shamt;
    logic [WIDTH-1:0] result_d, work_d;
    logic             illegal_d, shift_go;

    assign shamt = b[4:0];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        result_d  = '0;
        illegal_d = 1'b0;
        case (ALUcontrol)
            OP_AND:  result_d = a & b;
            OP_OR:   result_d = a | b;
            OP_ADD:  result_d = a + b;
            OP_SUB:  result_d = a - b;
            OP_XOR:  result_d = a ^ b;
            OP_NOR:  result_d = ~(a | b);
            OP_SLTU: result_d[0] = (a < b);
`ifdef ITER_ALU_BARREL_SHIFT_EN
            OP_SLL:  result_d = a << shamt;
            OP_SRL:  result_d = a >> shamt;
`else
            // Only reached with shamt == 0; nonzero shifts take the SHIFT path.
            OP_SLL,
            OP_SRL:  result_d = a;
`endif
            default: illegal_d = 1'b1;
        endcase
    end

`ifdef ITER_ALU_BARREL_SHIFT_EN
    assign shift_go = 1'b0;
`else
    assign shift_go = ((ALUcontrol == OP_SLL) || (ALUcontrol == OP_SRL)) && (shamt != 5'd0);
`endif

    assign work_d = left_q ? (work_q << 1) : (work_q >> 1);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
            work_q    <= '0;
            left_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        ready_q <= 1'b0;
                        if (shift_go) begin
                            work_q  <= a;
                            cnt_q   <= shamt;
                            left_q  <= (ALUcontrol == OP_SLL);
                            state_q <= SHIFT;
                        end else begin
                            result_q  <= result_d;
                            zero_q    <= (result_d == '0);
                            illegal_q <= illegal_d;
                            done_q    <= 1'b1;
                            state_q   <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        result_q  <= work_d;
                        zero_q    <= (work_d == '0);
                        illegal_q <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready   = ready_q;
    assign done    = done_q;
    assign result  = result_q;
    assign zero    = zero_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_iter_alu.sv
// Directed bench for iter_alu: vector table for single operations plus hand sequences
// for start-during-SHIFT and reset-mid-SHIFT. Honours ITER_ALU_BARREL_SHIFT_EN for shift latency.
module tb_iter_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  ALUcontrol = 4'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        ready, done, zero, illegal;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

`ifdef ITER_ALU_BARREL_SHIFT_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    iter_alu #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ALUcontrol (ALUcontrol),
        .a          (a),
        .b          (b),
        .ready      (ready),
        .done       (done),
        .result     (result),
        .zero       (zero),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] av;
        logic [31:0] bv;
        logic [31:0] res;
        logic        z;
        logic        il;
        int          lat;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic int shift_lat(input int n);
        return BARREL ? 1 : n + 1;
    endfunction

    // Call right after a negedge with ready=1; returns at a negedge with ready=1 again.
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] av,
                          input logic [31:0] bv, output logic [31:0] res, output logic z,
                          output logic il, output int lat);
        check({name, "_ready_before"}, 32'(ready), 32'd1);
        ALUcontrol = op; a = av; b = bv; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_done_seen"}, 32'(done), 32'd1);
        res = result; z = zero; il = illegal;
        check({name, "_ready_in_done"}, 32'(ready), 32'd0);
        @(negedge clk);
        check({name, "_done_one_cycle"}, 32'(done), 32'd0);
        check({name, "_ready_after"}, 32'(ready), 32'd1);
    endtask

    initial begin
        logic [31:0] res, prev;
        logic        z, il;
        int          lat, dones;

        vecs[0]  = '{"add_wrap",   4'd2,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1};
        vecs[1]  = '{"and",        4'd0,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 1'b0, 1};
        vecs[2]  = '{"or",         4'd1,  32'h0F00_0000, 32'h0000_00F0, 32'h0F00_00F0, 1'b0, 1'b0, 1};
        vecs[3]  = '{"xor",        4'd9,  32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 1'b0, 1'b0, 1};
        vecs[4]  = '{"nor_zeros",  4'd12, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1};
        vecs[5]  = '{"nor_ones",   4'd12, 32'hFFFF_0000, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1};
        vecs[6]  = '{"sub_neg",    4'd6,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0, 1};
        vecs[7]  = '{"sub_eq",     4'd6,  32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b1, 1'b0, 1};
        vecs[8]  = '{"illegal5",   4'd5,  32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1};
        vecs[9]  = '{"sltu_lt",    4'd14, 32'h0000_0003, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1};
        vecs[10] = '{"sltu_ge",    4'd14, 32'hFFFF_FFFF, 32'h0000_0003, 32'h0000_0000, 1'b1, 1'b0, 1};
        vecs[11] = '{"illegal15",  4'd15, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1};
        vecs[12] = '{"sll_5",      4'd3,  32'h0000_0001, 32'h0000_0005, 32'h0000_0020, 1'b0, 1'b0, shift_lat(5)};
        vecs[13] = '{"sll_shamt0", 4'd3,  32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0, 1'b0, 1};
        vecs[14] = '{"srl_4",      4'd4,  32'hF000_000F, 32'h0000_0004, 32'h0F00_0000, 1'b0, 1'b0, shift_lat(4)};
        vecs[15] = '{"sll_1",      4'd3,  32'h8000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, shift_lat(1)};
        vecs[16] = '{"sll_out",    4'd3,  32'h0000_0100, 32'h0000_0018, 32'h0000_0000, 1'b1, 1'b0, shift_lat(24)};
        vecs[17] = '{"add",        4'd2,  32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0, 1};

        // Reset values while rst_n is held low.
        repeat (2) @(negedge clk);
        check("rst_ready",   32'(ready),   32'd1);
        check("rst_done",    32'(done),    32'd0);
        check("rst_result",  result,       32'd0);
        check("rst_zero",    32'(zero),    32'd1);
        check("rst_illegal", 32'(illegal), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].av, vecs[i].bv, res, z, il, lat);
            check({vecs[i].name, "_result"},  res,      vecs[i].res);
            check({vecs[i].name, "_zero"},    32'(z),   32'(vecs[i].z));
            check({vecs[i].name, "_illegal"}, 32'(il),  32'(vecs[i].il));
            check({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].lat));
        end

        // SRL by 31 with start pulses during SHIFT: ignored, result held until completion.
        prev = vecs[NV-1].res;
        ALUcontrol = 4'd4; a = 32'h8000_0000; b = 32'd31; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            check("srl31_result_held", result, prev);
            check("srl31_ready_low", 32'(ready), 32'd0);
            if (lat % 4 == 0) begin
                ALUcontrol = 4'd2; a = 32'd1; b = 32'd1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("srl31_done_seen", 32'(done), 32'd1);
        check("srl31_result", result, 32'h0000_0001);
        check("srl31_latency", 32'(lat), 32'(shift_lat(31)));
        @(negedge clk);
        check("srl31_done_pulse", 32'(done), 32'd0);
        @(negedge clk);
        check("srl31_not_queued", 32'(done), 32'd0);
        check("srl31_result_kept", result, 32'h0000_0001);

        // Reset 3 cycles into SLL by 10: abandon with no done pulse.
        ALUcontrol = 4'd3; a = 32'd1; b = 32'd10; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_ready",   32'(ready),   32'd1);
        check("rstmid_result",  result,       32'd0);
        check("rstmid_zero",    32'(zero),    32'd1);
        check("rstmid_done",    32'(done),    32'd0);
        check("rstmid_illegal", 32'(illegal), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("rstmid_no_done", 32'(dones), 32'd0);
        check("rstmid_ready_after", 32'(ready), 32'd1);
        check("rstmid_result_after", result, 32'd0);

        run_op("post_rst_add", 4'd2, 32'd2, 32'd3, res, z, il, lat);
        check("post_rst_add_result", res, 32'd5);
        check("post_rst_add_latency", 32'(lat), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
